// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: op enumeration, MIPS32 opcode/funct constants, FSM state type and word builders
package instr_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLTU, OP_ADDU, OP_SUBU,
        OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_JR, OP_JALR, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
        OP_LI32
    } op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

`ifdef INSTR_ENC_PSEUDO_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LI_HI, ST_LI_LO} state_t;
`else
    typedef enum logic {ST_IDLE} state_t;
`endif

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/instr_enc_table.sv
// instr_enc_table: combinational map from abstract op and fields to a MIPS32 word plus illegal flag
module instr_enc_table
    import instr_enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [15:0] imm16;
    assign imm16 = imm[15:0];

    // One word per op; fields the op does not use are tied to zero, LI32 is left to the caller
    always_comb begin
        word = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            OP_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            OP_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
            OP_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
            OP_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
            OP_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
            OP_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
            OP_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
            OP_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
            OP_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
            OP_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            OP_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
            OP_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
            OP_SRLV:  word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
            OP_SRAV:  word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
            OP_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_JALR:  word = r_word(rs, 5'd0, 5'd31, 5'd0, FN_JALR);
            OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm16);
            OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm16);
            OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm16);
            OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm16);
            OP_XORI:  word = i_word(OPC_XORI, rs, rt, imm16);
            OP_LUI:   word = i_word(OPC_LUI, 5'd0, rt, imm16);
            OP_SLTI:  word = i_word(OPC_SLTI, rs, rt, imm16);
            OP_SLTIU: word = i_word(OPC_SLTIU, rs, rt, imm16);
            OP_LW:    word = i_word(OPC_LW, rs, rt, imm16);
            OP_SW:    word = i_word(OPC_SW, rs, rt, imm16);
            OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm16);
            OP_BNE:   word = i_word(OPC_BNE, rs, rt, imm16);
            OP_J:     word = j_word(OPC_J, imm);
            OP_JAL:   word = j_word(OPC_JAL, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: abstract request -> MIPS32 word stream with one-word output register; LI32 pseudo-op under INSTR_ENC_PSEUDO_EN
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);
    import instr_enc_pkg::*;

    logic [31:0] tbl_word;
    logic        tbl_illegal;
    logic [31:0] acc_word;
    logic [31:0] pend_word;
    logic        illegal;
    logic        accept;
    logic        drain;
    logic        reload;
    logic        idle_ok;
    logic        run;

    instr_enc_table u_table (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm[25:0]),
        .word    (tbl_word),
        .illegal (tbl_illegal)
    );

    assign drain    = out_valid && out_ready;
    assign in_ready = run && idle_ok && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Hold off requests until the first clock after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) run <= 1'b0;
        else       run <= 1'b1;
    end

`ifdef INSTR_ENC_PSEUDO_EN
    state_t      state;
    state_t      state_nx;
    logic        is_li;
    logic        li_split;
    logic [31:0] li_word;

    assign is_li    = in_op == OP_LI32;
    assign li_split = is_li && in_imm[31:16] != '0 && in_imm[15:0] != '0;
    assign li_word  = in_imm[31:16] == '0 ? i_word(OPC_ORI, 5'd0, in_rt, in_imm[15:0])
                                          : i_word(OPC_LUI, 5'd0, in_rt, in_imm[31:16]);
    assign illegal  = tbl_illegal && !is_li;
    assign acc_word = is_li ? li_word : tbl_word;
    assign reload   = drain && state == ST_LI_HI;
    assign idle_ok  = state == ST_IDLE;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // A split LI32 walks through the LUI word then the ORI word, each left on its handshake
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept && li_split) state_nx = ST_LI_HI;
            ST_LI_HI: if (drain) state_nx = ST_LI_LO;
            ST_LI_LO: if (drain) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Park the ORI half of a split LI32 until the LUI word leaves
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    pend_word <= '0;
        else if (accept && li_split) pend_word <= i_word(OPC_ORI, in_rt, in_rt, in_imm[15:0]);
    end
`else
    logic unused_imm_hi;

    assign unused_imm_hi = ^in_imm[31:26];
    assign illegal       = tbl_illegal;
    assign acc_word      = tbl_word;
    assign reload        = 1'b0;
    assign pend_word     = '0;
    assign idle_ok       = 1'b1;
`endif

    // Output register, one-cycle error pulse and handshake counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            err       <= 1'b0;
            word_cnt  <= '0;
        end else begin
            err <= accept && illegal;
            if (drain) word_cnt <= word_cnt + CNT_W'(1);
            if (accept) begin
                out_valid <= !illegal;
                if (!illegal) out_instr <= acc_word;
            end else if (reload) begin
                out_instr <= pend_word;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboarded random and directed bench for instr_encoder (LI32 cases under INSTR_ENC_PSEUDO_EN)
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] word_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [31:0] exp_q[$];
    bit err_exp[int];
    bit valid_due[int];
    logic [15:0] model_cnt = '0;
    bit prev_hold = 0;
    logic [31:0] prev_word = '0;

    int fn_tab[18]  = '{32, 34, 36, 37, 42, 43, 33, 35, 38, 39, 0, 2, 3, 4, 6, 7, 8, 9};
    int opc_tab[12] = '{8, 9, 12, 13, 14, 15, 10, 11, 35, 43, 4, 5};

    instr_encoder dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input longint opc, input longint rs, input longint rt, input longint low);
        return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + low);
    endfunction

    // Reference: words the request should produce (0 means illegal)
    function automatic int model(input int op, input int rs, input int rt, input int rd, input int sh,
                                 input logic [31:0] imm, output logic [31:0] w0, output logic [31:0] w1);
        int s, t, d, a;
        longint hi, lo;
        w0 = '0;
        w1 = '0;
        hi = imm / 65536;
        lo = imm % 65536;
        if (op < 18) begin
            s = rs; t = rt; d = rd; a = 0;
            if (op >= 10 && op <= 12) begin s = 0; a = sh; end
            if (op == 16) begin t = 0; d = 0; end
            if (op == 17) begin t = 0; d = 31; end
            w0 = fld(0, s, t, d * 2048 + a * 64 + fn_tab[op]);
            return 1;
        end
        if (op < 30) begin
            w0 = fld(opc_tab[op-18], op == 23 ? 0 : rs, rt, lo);
            return 1;
        end
        if (op < 32) begin
            w0 = fld(op - 28, 0, 0, imm % 67108864);
            return 1;
        end
`ifdef INSTR_ENC_PSEUDO_EN
        if (op == 32) begin
            if (hi == 0) begin w0 = fld(13, 0, rt, lo); return 1; end
            w0 = fld(15, 0, rt, hi);
            if (lo == 0) return 1;
            w1 = fld(13, rt, rt, lo);
            return 2;
        end
`endif
        return 0;
    endfunction

    // Offer one request; decide acceptance at the negedge and log expectations for the monitor
    task automatic send(input int op, input int rs, input int rt, input int rd, input int sh, input logic [31:0] imm);
        int n;
        logic [31:0] w0, w1;
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh); in_imm = imm;
            if (in_ready) begin
                ok = 1;
                n = model(op, rs, rt, rd, sh, imm, w0, w1);
                if (n == 0) err_exp[cyc+1] = 1;
                else begin
                    valid_due[cyc+1] = 1;
                    exp_q.push_back(w0);
                    if (n == 2) exp_q.push_back(w1);
                end
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op %0d, want 1", op);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: queue=%0d out_valid=%0b, want empty", exp_q.size(), out_valid);
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);
    endtask

    // Sink: always ready, stalled, or random
    initial forever begin
        @(posedge clk);
        #2 out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom % 4 != 0);
    end

    // Monitor: stability, latency, error pulse and scoreboard compare on each handshake
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            err_exp.delete();
            valid_due.delete();
            model_cnt = '0;
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_instr", out_instr, prev_word);
            end
            prev_hold = out_valid && !out_ready;
            prev_word = out_instr;
            chk("err", err, err_exp.exists(cyc));
            if (valid_due.exists(cyc)) chk("latency_valid", out_valid, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got %h want none", out_instr);
                end else chk("word", out_instr, exp_q.pop_front());
                chk("word_cnt", word_cnt, model_cnt);
                model_cnt = model_cnt + 16'd1;
            end
        end
    end

    initial begin
        logic [15:0] c0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_err", err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        release_reset();

        send(0, 1, 2, 3, 0, 32'h0);
        @(negedge clk);
        chk("add_word", out_instr, 32'h00221820);
        chk("add_valid", out_valid, 1);
        wait_drain();
        chk("add_cnt", word_cnt, 1);

        ready_mode = 2;
        c0 = word_cnt;
        send(27, 29, 5, 0, 0, 32'h8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sw_valid", out_valid, 1);
            chk("sw_word", out_instr, 32'hAFA50008);
            chk("sw_in_ready", in_ready, 0);
        end
        ready_mode = 0;
        wait_drain();
        chk("sw_cnt", word_cnt, 32'(c0 + 16'd1));

        c0 = word_cnt;
        send(63, 1, 2, 3, 4, 32'hFFFF);
        @(negedge clk);
        chk("ill63_err", err, 1);
        chk("ill63_valid", out_valid, 0);
        @(negedge clk);
        chk("ill63_err_off", err, 0);
        chk("ill63_cnt", word_cnt, c0);

`ifdef INSTR_ENC_PSEUDO_EN
        c0 = word_cnt;
        send(32, 0, 4, 0, 0, 32'h12345678);
        @(negedge clk);
        chk("li_lui", out_instr, 32'h3C041234);
        chk("li_lui_in_ready", in_ready, 0);
        @(negedge clk);
        chk("li_ori", out_instr, 32'h34845678);
        chk("li_ori_in_ready", in_ready, 0);
        wait_drain();
        chk("li_cnt", word_cnt, 32'(c0 + 16'd2));
        send(32, 0, 4, 0, 0, 32'h00005678);
        @(negedge clk);
        chk("li_lo_only", out_instr, 32'h34045678);
        @(negedge clk);
        chk("li_lo_single", out_valid, 0);
        send(32, 0, 4, 0, 0, 32'h12340000);
        @(negedge clk);
        chk("li_hi_only", out_instr, 32'h3C041234);
        @(negedge clk);
        chk("li_hi_single", out_valid, 0);
        send(32, 0, 4, 0, 0, 32'h0);
        @(negedge clk);
        chk("li_zero", out_instr, 32'h34040000);
        wait_drain();

        send(32, 0, 4, 0, 0, 32'h12345678);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", word_cnt, 0);
`else
        c0 = word_cnt;
        send(32, 0, 4, 0, 0, 32'h12345678);
        @(negedge clk);
        chk("li_ill_err", err, 1);
        chk("li_ill_valid", out_valid, 0);
        @(negedge clk);
        chk("li_ill_cnt", word_cnt, c0);

        ready_mode = 2;
        send(1, 7, 8, 9, 0, 32'h0);
        @(negedge clk);
        chk("held_valid", out_valid, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", word_cnt, 0);
        chk("mid_rst_instr", out_instr, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        ready_mode = 0;
`endif
        repeat (2) @(negedge clk);
        release_reset();
        repeat (4) @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_cnt", word_cnt, 0);

        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            int op;
            logic [31:0] imm;
            op = ($urandom % 8 == 0) ? 32 + int'($urandom % 32) : int'($urandom % 33);
            imm = $urandom;
            if (op == 32) begin
                case ($urandom % 4)
                    0: imm[31:16] = '0;
                    1: imm[15:0] = '0;
                    2: imm = '0;
                    default: ;
                endcase
            end
            send(op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), imm);
            if ($urandom % 5 == 0) repeat ($urandom % 3) @(posedge clk);
        end
        ready_mode = 0;
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_cnt", word_cnt, model_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
